key_array_driver: RTL and testbench

- Multi-channel push-button front end: per channel it does a 2-FF input synchroniser, a debounce timer, and a press-event state machine.
- Each channel reports a debounced level plus one-cycle press, release, click (short press), long-press and auto-repeat pulses.
- Sits between board key pins and UI/control logic. Replaces single-key debounce instances with one parametrised array.

---
 rtl/key_array_driver.sv | 190 +++++++++++++++++++
 tb/tb_key_array_driver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_array_driver.sv
// key_array_driver
//
// Multi-channel push-button front end. For each key channel:
//   2-FF synchroniser -> debounce timer -> press-event FSM (IDLE/HOLD/LONG).
// Each channel reports a debounced level and one-cycle event pulses. All
// outputs are registered.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   button_in    [CH] raw key pins (asynchronous to clk)
//   key_en       [CH] per-channel event enable (level still tracks when 0)
//   key_level    [CH] debounced state, 1 = pressed
//   key_press    [CH] 1-cycle pulse when key_level rises
//   key_release  [CH] 1-cycle pulse when key_level falls
//   key_click    [CH] 1-cycle pulse on release before the long-press time
//   key_long     [CH] 1-cycle pulse when the hold reaches LONG_CYC
//   key_repeat   [CH] 1-cycle pulse every RPT_CYC while held after long
//   any_event         OR of all pulse vectors, registered (one cycle later)
module key_array_driver #(
    parameter int CH          = 4,
    parameter int CYC_PER_MS  = 60000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] button_in,
    input  logic [CH-1:0] key_en,
    output logic [CH-1:0] key_level,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_release,
    output logic [CH-1:0] key_click,
    output logic [CH-1:0] key_long,
    output logic [CH-1:0] key_repeat,
    output logic          any_event
);

    localparam int DB_CYC   = DEBOUNCE_MS * CYC_PER_MS;
    localparam int LONG_CYC = LONG_MS * CYC_PER_MS;
    localparam int RPT_CYC  = REPEAT_MS * CYC_PER_MS;
    localparam int HOLD_MAX = (LONG_CYC > RPT_CYC) ? LONG_CYC : RPT_CYC;
    localparam int DBW      = $clog2(DB_CYC + 1);
    localparam int HW       = $clog2(HOLD_MAX + 1);
    // Guarded so a disabled repeat (RPT_CYC = 0) never yields a negative limit.
    localparam int RPT_LIM  = (RPT_CYC > 0) ? RPT_CYC - 1 : 0;
    localparam int LONG_LIM = (LONG_CYC > 0) ? LONG_CYC - 1 : 0;

    localparam logic          RPT_ON   = (RPT_CYC > 0);
    localparam logic          REL_PIN  = (ACTIVE_LOW != 0);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYC);
    localparam logic [HW-1:0]  LONG_MX = HW'(LONG_LIM);
    localparam logic [HW-1:0]  RPT_MX  = HW'(RPT_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;

    logic any_event_q;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic           sync1_q, sync2_q;
        logic [DBW-1:0] db_cnt_q, db_cnt_d;
        logic           level_q, level_d;
        state_t         state_q;
        logic [HW-1:0]  hold_cnt_q;
        logic           press_q, release_q, click_q, long_q, repeat_q;
        logic           pressed, db_sat, rise, fall;

        // Normalise polarity so 1 always means "pressed" from here on.
        assign pressed = sync2_q ^ REL_PIN;
        assign db_sat  = (db_cnt_q == DB_MAX);
        assign rise    = db_sat & pressed & ~level_q;
        assign fall    = db_sat & ~pressed & level_q;

        // The timer restarts whenever the synchroniser sees a transition, so
        // key_level only moves after DB_CYC cycles of a stable pin.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (sync1_q != sync2_q) begin
                db_cnt_d = '0;
            end else if (!db_sat) begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
            if (db_sat) begin
                level_d = pressed;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q  <= REL_PIN;
                sync2_q  <= REL_PIN;
                db_cnt_q <= '0;
                level_q  <= 1'b0;
            end else begin
                sync1_q  <= button_in[g];
                sync2_q  <= sync1_q;
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
            end
        end

        // Press-event FSM. A release seen in the same cycle as a long/repeat
        // threshold takes priority, so the threshold pulse is dropped.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= IDLE;
                hold_cnt_q <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                click_q    <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                press_q   <= rise & key_en[g];
                release_q <= fall & key_en[g];
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                if (!key_en[g]) begin
                    state_q    <= IDLE;
                    hold_cnt_q <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            // Only a fresh debounced rise arms the FSM; a key
                            // already held when enabled stays ignored.
                            if (rise) begin
                                state_q    <= HOLD;
                                hold_cnt_q <= '0;
                            end
                        end
                        HOLD: begin
                            if (fall) begin
                                click_q <= 1'b1;
                                state_q <= IDLE;
                            end else if (hold_cnt_q == LONG_MX) begin
                                long_q     <= 1'b1;
                                state_q    <= LONG;
                                hold_cnt_q <= '0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + HW'(1);
                            end
                        end
                        LONG: begin
                            if (fall) begin
                                state_q <= IDLE;
                            end else if (RPT_ON) begin
                                if (hold_cnt_q == RPT_MX) begin
                                    repeat_q   <= 1'b1;
                                    hold_cnt_q <= '0;
                                end else begin
                                    hold_cnt_q <= hold_cnt_q + HW'(1);
                                end
                            end
                        end
                        default: begin
                            state_q    <= IDLE;
                            hold_cnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_click[g]   = click_q;
        assign key_long[g]    = long_q;
        assign key_repeat[g]  = repeat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= |(key_press | key_release | key_click | key_long | key_repeat);
        end
    end

    assign any_event = any_event_q;

endmodule

// File: tb/tb_key_array_driver.sv
module tb_key_array_driver;

    logic       clk;
    logic       rst;
    logic [3:0] button_in;
    logic [3:0] key_en;
    logic [3:0] key_level, key_press, key_release, key_click, key_long, key_repeat;
    logic       any_event;

    int checks;
    int errors;
    int n_press   [4];
    int n_release [4];
    int n_click   [4];
    int n_long    [4];
    int n_repeat  [4];

    key_array_driver #(
        .CH(4), .CYC_PER_MS(10), .DEBOUNCE_MS(2), .LONG_MS(10),
        .REPEAT_MS(5), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .button_in(button_in), .key_en(key_en),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_click(key_click), .key_long(key_long), .key_repeat(key_repeat),
        .any_event(any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the edge and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (key_press[c])   n_press[c]++;
            if (key_release[c]) n_release[c]++;
            if (key_click[c])   n_click[c]++;
            if (key_long[c])    n_long[c]++;
            if (key_repeat[c])  n_repeat[c]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            n_press[c] = 0; n_release[c] = 0; n_click[c] = 0;
            n_long[c] = 0;  n_repeat[c] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button_in = 4'hF;
        key_en = 4'hF;
        ticks(3);
        checks++;
        if ({key_level, key_press, key_release, key_click, key_long, key_repeat, any_event} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {key_level, key_press, key_release, key_click, key_long, key_repeat, any_event});
        end
        rst = 1'b0;
        clear_counts();
        ticks(30);
        checks++;
        if (key_level !== 4'h0 || any_event !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: level=%h any=%b expected 0/0", key_level, any_event);
        end
    endtask

    task automatic test_click();
        clear_counts();
        button_in[0] = 1'b0;
        ticks(22);
        checks++;
        if (key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL click_level_early: got %b expected 0", key_level[0]);
        end
        tick();
        checks++;
        if (key_level[0] !== 1'b1 || key_press[0] !== 1'b1) begin
            errors++;
            $display("FAIL click_press_edge: level=%b press=%b expected 1/1", key_level[0], key_press[0]);
        end
        tick();
        checks++;
        if (key_press[0] !== 1'b0 || any_event !== 1'b1) begin
            errors++;
            $display("FAIL click_press_pulse: press=%b any=%b expected 0/1", key_press[0], any_event);
        end
        ticks(16);
        button_in[0] = 1'b1;
        ticks(22);
        checks++;
        if (key_level[0] !== 1'b1 || key_release[0] !== 1'b0) begin
            errors++;
            $display("FAIL click_release_early: level=%b rel=%b expected 1/0", key_level[0], key_release[0]);
        end
        tick();
        checks++;
        if (key_level[0] !== 1'b0 || key_release[0] !== 1'b1 || key_click[0] !== 1'b1) begin
            errors++;
            $display("FAIL click_release_edge: level=%b rel=%b click=%b expected 0/1/1",
                     key_level[0], key_release[0], key_click[0]);
        end
        ticks(5);
        checks++;
        if (n_press[0] != 1 || n_release[0] != 1 || n_click[0] != 1 || n_long[0] != 0 || n_repeat[0] != 0) begin
            errors++;
            $display("FAIL click_counts: p=%0d r=%0d c=%0d l=%0d rp=%0d expected 1/1/1/0/0",
                     n_press[0], n_release[0], n_click[0], n_long[0], n_repeat[0]);
        end
    endtask

    task automatic test_glitch();
        int lvl_bad;
        lvl_bad = 0;
        clear_counts();
        button_in[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (key_level[1] !== 1'b0) lvl_bad++;
        end
        button_in[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (key_level[1] !== 1'b0) lvl_bad++;
        end
        checks++;
        if (lvl_bad != 0) begin
            errors++;
            $display("FAIL glitch_level: high for %0d cycles expected 0", lvl_bad);
        end
        checks++;
        if (n_press[1] + n_release[1] + n_click[1] + n_long[1] + n_repeat[1] != 0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d pulses expected 0",
                     n_press[1] + n_release[1] + n_click[1] + n_long[1] + n_repeat[1]);
        end
    endtask

    task automatic test_long_repeat();
        logic exp_long, exp_rpt, exp_rel;
        clear_counts();
        button_in[2] = 1'b0;
        ticks(23);
        checks++;
        if (key_press[2] !== 1'b1) begin
            errors++;
            $display("FAIL long_press: got %b expected 1", key_press[2]);
        end
        // k = cycles since key_press; release first sampled so level falls at k=310
        for (int k = 1; k <= 312; k++) begin
            if (k == 288) button_in[2] = 1'b1;
            tick();
            exp_long = (k == 100);
            exp_rpt  = (k == 150) || (k == 200) || (k == 250) || (k == 300);
            exp_rel  = (k == 310);
            checks++;
            if (key_long[2] !== exp_long || key_repeat[2] !== exp_rpt ||
                key_release[2] !== exp_rel || key_click[2] !== 1'b0) begin
                errors++;
                $display("FAIL long_seq k=%0d: long=%b rpt=%b rel=%b click=%b expected %b/%b/%b/0",
                         k, key_long[2], key_repeat[2], key_release[2], key_click[2],
                         exp_long, exp_rpt, exp_rel);
            end
        end
        checks++;
        if (n_long[2] != 1 || n_repeat[2] != 4 || n_click[2] != 0) begin
            errors++;
            $display("FAIL long_counts: l=%0d rp=%0d c=%0d expected 1/4/0", n_long[2], n_repeat[2], n_click[2]);
        end
    endtask

    task automatic test_release_at_threshold();
        clear_counts();
        button_in[3] = 1'b0;
        ticks(23);
        checks++;
        if (key_press[3] !== 1'b1) begin
            errors++;
            $display("FAIL thr_press: got %b expected 1", key_press[3]);
        end
        // Level falls exactly at k=100, the cycle the long threshold would fire.
        for (int k = 1; k <= 110; k++) begin
            if (k == 78) button_in[3] = 1'b1;
            tick();
            checks++;
            if (key_long[3] !== 1'b0 || key_click[3] !== (k == 100) || key_release[3] !== (k == 100)) begin
                errors++;
                $display("FAIL thr_seq k=%0d: long=%b click=%b rel=%b expected 0/%b/%b",
                         k, key_long[3], key_click[3], key_release[3], k == 100, k == 100);
            end
        end
    endtask

    task automatic test_enable();
        clear_counts();
        key_en[0] = 1'b0;
        button_in[0] = 1'b0;
        ticks(23);
        checks++;
        if (key_level[0] !== 1'b1 || key_press[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_masked_press: level=%b press=%b expected 1/0", key_level[0], key_press[0]);
        end
        key_en[0] = 1'b1;
        ticks(150);
        checks++;
        if (n_press[0] + n_click[0] + n_long[0] + n_repeat[0] + n_release[0] != 0) begin
            errors++;
            $display("FAIL en_held_pulses: got %0d expected 0",
                     n_press[0] + n_click[0] + n_long[0] + n_repeat[0] + n_release[0]);
        end
        button_in[0] = 1'b1;
        ticks(30);
        checks++;
        if (key_level[0] !== 1'b0 || n_click[0] != 0 || n_press[0] != 0 || n_long[0] != 0) begin
            errors++;
            $display("FAIL en_release: level=%b click=%0d press=%0d long=%0d expected 0/0/0/0",
                     key_level[0], n_click[0], n_press[0], n_long[0]);
        end
        button_in[0] = 1'b0;
        ticks(23);
        checks++;
        if (key_press[0] !== 1'b1) begin
            errors++;
            $display("FAIL en_repress: got %b expected 1", key_press[0]);
        end
        button_in[0] = 1'b1;
        ticks(30);
        checks++;
        if (n_click[0] != 1) begin
            errors++;
            $display("FAIL en_click_after_repress: got %0d expected 1", n_click[0]);
        end
    endtask

    task automatic test_reset_midhold();
        clear_counts();
        button_in = 4'b1010;
        ticks(23);
        checks++;
        if (key_press !== 4'b0101) begin
            errors++;
            $display("FAIL mh_press_both: got %b expected 0101", key_press);
        end
        ticks(30);
        rst = 1'b1;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_click, key_long, key_repeat, any_event} !== 25'd0) begin
            errors++;
            $display("FAIL mh_reset_async: got %h expected 0",
                     {key_level, key_press, key_release, key_click, key_long, key_repeat, any_event});
        end
        ticks(3);
        checks++;
        if ({key_level, key_press, key_release, key_click, key_long, key_repeat, any_event} !== 25'd0) begin
            errors++;
            $display("FAIL mh_reset_hold: got %h expected 0",
                     {key_level, key_press, key_release, key_click, key_long, key_repeat, any_event});
        end
        rst = 1'b0;
        clear_counts();
        ticks(22);
        checks++;
        if (key_level !== 4'b0000 || n_release[0] + n_release[2] != 0) begin
            errors++;
            $display("FAIL mh_redebounce: level=%b releases=%0d expected 0000/0",
                     key_level, n_release[0] + n_release[2]);
        end
        tick();
        checks++;
        if (key_press !== 4'b0101 || key_level !== 4'b0101 || any_event !== 1'b0) begin
            errors++;
            $display("FAIL mh_press_after: press=%b level=%b any=%b expected 0101/0101/0",
                     key_press, key_level, any_event);
        end
        tick();
        checks++;
        if (any_event !== 1'b1 || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL mh_any_event: any=%b press=%b expected 1/0000", any_event, key_press);
        end
        button_in = 4'hF;
        ticks(30);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        button_in = 4'hF;
        key_en = 4'hF;
        clear_counts();
        test_reset();
        test_click();
        test_glitch();
        test_long_repeat();
        test_release_at_threshold();
        test_enable();
        test_reset_midhold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
